enigma_stream_core: RTL

- Parametrised Enigma-style byte-stream cipher core: NUM_ROTORS stepping rotors and a fixed-point-free reflector.
- Each rotor is an affine permutation mod 26.
- Sits between the UART RX byte stream and the UART TX byte stream in the encryptor top.
- Valid/ready handshakes on both sides.
- Rotor positions are loadable from switches and exported for 7-seg/LED display.

---
 rtl/enigma_stream_core.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/enigma_stream_core.sv
// Enigma-style byte-stream cipher: stepping affine rotors plus a reflector.
// Letters are encrypted one rotor per cycle, and non-letters pass straight through.
module enigma_stream_core #(
    parameter int                      NUM_ROTORS = 3,
    parameter logic [5*NUM_ROTORS-1:0] ROTOR_A    = {5'd7, 5'd5, 5'd3},
    parameter logic [5*NUM_ROTORS-1:0] ROTOR_AINV = {5'd15, 5'd21, 5'd9},
    parameter logic [5*NUM_ROTORS-1:0] ROTOR_B    = {5'd3, 5'd2, 5'd1},
    parameter logic [5*NUM_ROTORS-1:0] NOTCH      = {5'd25, 5'd25, 5'd25},
    parameter logic [5*NUM_ROTORS-1:0] INIT_POS   = '0,
    parameter int                      REFL_K     = 25
) (
    input  logic                    msclk,
    input  logic                    btnR,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    input  logic                    cfg_load,
    input  logic [5*NUM_ROTORS-1:0] cfg_pos,
    output logic [5*NUM_ROTORS-1:0] rotor_pos
);

    localparam int IW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_ROTORS - 1);

    typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BWD, OUT} state_t;
    state_t state, state_nx;

    logic [IW-1:0] idx;
    logic [4:0]    pos      [NUM_ROTORS];
    logic [4:0]    pos_step [NUM_ROTORS];
    logic [4:0]    pos_cfg  [NUM_ROTORS];
    logic [4:0]    rot_a    [NUM_ROTORS];
    logic [4:0]    rot_ai   [NUM_ROTORS];
    logic [4:0]    rot_b    [NUM_ROTORS];
    logic [4:0]    rot_n    [NUM_ROTORS];
    logic [4:0]    cur;
    logic          lower;
    logic [7:0]    out_q;
    logic          carry;
    logic          is_letter;
    logic          accept;

    logic [4:0]  p, ka, kai, kb;
    logic [5:0]  fsum;
    logic [4:0]  ft;
    logic [10:0] fprod;
    logic [6:0]  bsum;
    logic [4:0]  bt;
    logic [10:0] bprod;
    logic [5:0]  rsum;
    logic [4:0]  fwd_res, bwd_res, refl_res;

    assign is_letter = ((in_data >= 8'h41) && (in_data <= 8'h5A)) ||
                       ((in_data >= 8'h61) && (in_data <= 8'h7A));
    assign accept    = (state == IDLE) && !cfg_load && in_valid;
    assign out_data  = out_q;

    // Rotor tables, stepping carry chain, config reduction and position export
    always_comb begin
        carry = 1'b1;
        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
            rot_a[i]  = ROTOR_A[5*i +: 5];
            rot_ai[i] = ROTOR_AINV[5*i +: 5];
            rot_b[i]  = ROTOR_B[5*i +: 5];
            rot_n[i]  = NOTCH[5*i +: 5];
            pos_step[i] = pos[i];
            if (carry)
                pos_step[i] = (pos[i] == 5'd25) ? 5'd0 : pos[i] + 5'd1;
            carry = carry && (pos[i] == rot_n[i]);
            pos_cfg[i] = (cfg_pos[5*i +: 5] >= 5'd26) ? cfg_pos[5*i +: 5] - 5'd26
                                                      : cfg_pos[5*i +: 5];
            rotor_pos[5*i +: 5] = pos[i];
        end
    end

    always_comb begin
        p   = pos[idx];
        ka  = rot_a[idx];
        kai = rot_ai[idx];
        kb  = rot_b[idx];

        fsum    = {1'b0, cur} + {1'b0, p};
        ft      = (fsum >= 6'd26) ? 5'(fsum - 6'd26) : fsum[4:0];
        fprod   = 11'(ka) * 11'(ft) + 11'(kb) + 11'd26 - 11'(p);
        fwd_res = 5'(fprod % 11'd26);

        bsum    = 7'(cur) + 7'(p) + 7'd26 - 7'(kb);
        bt      = 5'(bsum % 7'd26);
        bprod   = 11'(kai) * 11'(bt) + 11'd26 - 11'(p);
        bwd_res = 5'(bprod % 11'd26);

        rsum     = 6'(REFL_K) + 6'd26 - 6'(cur);
        refl_res = 5'(rsum % 6'd26);
    end

    always_ff @(posedge msclk or posedge btnR) begin
        if (btnR) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = is_letter ? STEP : OUT;
            STEP: state_nx = FWD;
            FWD:  if (idx == LAST) state_nx = REFL;
            REFL: state_nx = BWD;
            BWD:  if (idx == '0) state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    always_ff @(posedge msclk or posedge btnR) begin
        if (btnR) begin
            idx   <= '0;
            cur   <= '0;
            lower <= 1'b0;
            out_q <= '0;
            for (int unsigned i = 0; i < NUM_ROTORS; i++)
                pos[i] <= INIT_POS[5*i +: 5];
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        for (int unsigned i = 0; i < NUM_ROTORS; i++)
                            pos[i] <= pos_cfg[i];
                    end else if (in_valid) begin
                        if (is_letter) begin
                            // 'A' and 'a' both have 5'd1 in their low bits
                            cur   <= in_data[4:0] - 5'd1;
                            lower <= in_data[5];
                        end else begin
                            out_q <= in_data;
                        end
                    end
                end
                STEP: begin
                    for (int unsigned i = 0; i < NUM_ROTORS; i++)
                        pos[i] <= pos_step[i];
                    idx <= '0;
                end
                FWD: begin
                    cur <= fwd_res;
                    if (idx != LAST) idx <= idx + 1'b1;
                end
                REFL: begin
                    cur <= refl_res;
                    idx <= LAST;
                end
                BWD: begin
                    cur <= bwd_res;
                    if (idx == '0) out_q <= {2'b01, lower, bwd_res + 5'd1};
                    else           idx   <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
